mvau_wmem_sched: RTL and testbench

- Controller that sequences one MVAU weight memory through a full matrix-vector pass.
- Per accepted input vector, issues SF*NF weight-memory addresses in neuron-fold-major order, with matching input-buffer indices and accumulator first/last markers.
- The weight memory has a 1-cycle registered read and no read enable. The scheduler therefore steers the address so that the memory output stays stable under downstream back-pressure.
- Sits between the input-vector buffer, the weight memory and the PE/SIMD compute array.

---
 rtl/mvau_wmem_sched_pkg.sv | 15 +
 rtl/mvau_wmem_sched_if.sv | 34 +++
 rtl/mvau_wmem_sched_fold_cnt.sv | 30 +++
 rtl/mvau_wmem_sched.sv | 147 ++++++++++++++
 tb/tb_mvau_wmem_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mvau_wmem_sched_pkg.sv
// Shared types and helpers for the MVAU weight-memory scheduler.
package mvau_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvau_wmem_sched_if.sv
// Scheduler-side bundle: vector handshake, weight-memory address and beat metadata.
interface mvau_wmem_sched_if #(
    parameter int SF = 4,
    parameter int NF = 2
) ();
    import mvau_sched_pkg::*;

    localparam int WMEM_ADDR_BW = clog2_min1(SF * NF);
    localparam int SF_BW        = clog2_min1(SF);
    localparam int NF_BW        = clog2_min1(NF);

    logic                    vec_valid;
    logic                    vec_ready;
    logic [WMEM_ADDR_BW-1:0] wmem_addr;
    logic [SF_BW-1:0]        ibuf_addr;
    logic                    w_valid;
    logic                    w_ready;
    logic                    w_first;
    logic                    w_last;
    logic [NF_BW-1:0]        w_nf;
    logic                    busy;
    logic                    done;

    modport master (
        input  vec_valid, w_ready,
        output vec_ready, wmem_addr, ibuf_addr, w_valid, w_first, w_last, w_nf, busy, done
    );

    modport slave (
        output vec_valid, w_ready,
        input  vec_ready, wmem_addr, ibuf_addr, w_valid, w_first, w_last, w_nf, busy, done
    );

endinterface

// File: rtl/mvau_wmem_sched_fold_cnt.sv
// Modulo-MAX fold counter; o_wrap flags the terminal count MAX-1.
module mvau_fold_cnt
    import mvau_sched_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = clog2_min1(MAX)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;

    assign o_wrap = (r_cnt == W'(MAX - 1));
    assign o_cnt  = r_cnt;

    // Count enabled steps, folding back to zero after the terminal value.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mvau_wmem_sched.sv
// Sequences one weight memory through SF*NF reads per vector, neuron-fold major.
// The memory has a registered read with no enable, so the address is steered
// back to the presented beat whenever the consumer stalls.
module mvau_wmem_sched #(
    parameter int SF         = 4,
    parameter int NF         = 2,
    parameter int WMEM_DEPTH = SF * NF
) (
    input  logic              aclk,
    input  logic              rst,
    mvau_wmem_sched_if.master bus
);
    import mvau_sched_pkg::*;

    localparam int WMEM_ADDR_BW = clog2_min1(WMEM_DEPTH);
    localparam int SF_BW        = clog2_min1(SF);
    localparam int NF_BW        = clog2_min1(NF);
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    sched_state_e            r_state;
    sched_state_e            w_state_nxt;
    logic                    w_adv;
    logic                    w_issue;
    logic                    w_accept;
    logic                    w_vec_ready;
    logic                    w_busy;
    logic                    w_drain_ack;
    logic                    w_sf_wrap;
    logic                    w_nf_wrap;
    logic [SF_BW-1:0]        w_sf_cnt;
    logic [NF_BW-1:0]        w_nf_cnt;
    logic [WMEM_ADDR_BW-1:0] r_nxt_addr;
    logic [WMEM_ADDR_BW-1:0] r_pres_addr;

    logic                    r_w_valid_p1;
    logic                    r_w_first_p1;
    logic                    r_w_last_p1;
    logic [SF_BW-1:0]        r_ibuf_addr_p1;
    logic [NF_BW-1:0]        r_w_nf_p1;
    logic                    r_done_p1;

    assign w_adv = !r_w_valid_p1 || bus.w_ready;

    mvau_fold_cnt #(.MAX(SF), .W(SF_BW)) u_sf_cnt (
        .i_clk  (aclk),
        .i_rst  (rst),
        .i_clr  (w_accept),
        .i_en   (w_issue),
        .o_cnt  (w_sf_cnt),
        .o_wrap (w_sf_wrap)
    );

    mvau_fold_cnt #(.MAX(NF), .W(NF_BW)) u_nf_cnt (
        .i_clk  (aclk),
        .i_rst  (rst),
        .i_clr  (w_accept),
        .i_en   (w_issue && w_sf_wrap),
        .o_cnt  (w_nf_cnt),
        .o_wrap (w_nf_wrap)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the decoded accept/issue/drain strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_ready = 1'b0;
        w_busy      = 1'b1;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_drain_ack = 1'b0;
        case (r_state)
            IDLE: begin
                w_vec_ready = 1'b1;
                w_busy      = 1'b0;
                if (bus.vec_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_adv) begin
                    w_issue = 1'b1;
                    if (r_nxt_addr == LAST_ADDR) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.w_ready) begin
                    w_drain_ack = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Address bookkeeping and the beat metadata that travels with the memory read.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_nxt_addr     <= '0;
            r_pres_addr    <= '0;
            r_w_valid_p1   <= 1'b0;
            r_w_first_p1   <= 1'b0;
            r_w_last_p1    <= 1'b0;
            r_ibuf_addr_p1 <= '0;
            r_w_nf_p1      <= '0;
            r_done_p1      <= 1'b0;
        end else begin
            r_done_p1 <= w_drain_ack;
            if (w_accept) begin
                r_nxt_addr <= '0;
            end else if (w_issue) begin
                r_w_valid_p1   <= 1'b1;
                r_pres_addr    <= r_nxt_addr;
                r_ibuf_addr_p1 <= w_sf_cnt;
                r_w_nf_p1      <= w_nf_cnt;
                r_w_first_p1   <= (w_sf_cnt == '0);
                r_w_last_p1    <= w_sf_wrap;
                r_nxt_addr     <= (w_sf_wrap && w_nf_wrap) ? '0 : r_nxt_addr + 1'b1;
            end else if (w_drain_ack) begin
                r_w_valid_p1 <= 1'b0;
            end
        end
    end

    assign bus.wmem_addr = w_issue ? r_nxt_addr : r_pres_addr;
    assign bus.vec_ready = w_vec_ready;
    assign bus.busy      = w_busy;
    assign bus.w_valid   = r_w_valid_p1;
    assign bus.w_first   = r_w_first_p1;
    assign bus.w_last    = r_w_last_p1;
    assign bus.ibuf_addr = r_ibuf_addr_p1;
    assign bus.w_nf      = r_w_nf_p1;
    assign bus.done      = r_done_p1;

endmodule

// File: tb/tb_mvau_wmem_sched.sv
// Directed bench for mvau_wmem_sched: three configurations, each with a
// registered-read weight memory model attached to its address port.
module tb_mvau_wmem_sched;

    logic aclk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mvau_wmem_sched_if #(.SF(3), .NF(2)) ifA ();
    mvau_wmem_sched_if #(.SF(1), .NF(1)) ifB ();
    mvau_wmem_sched_if #(.SF(4), .NF(3)) ifC ();

    mvau_wmem_sched #(.SF(3), .NF(2), .WMEM_DEPTH(6))  dutA (.aclk(aclk), .rst(rst), .bus(ifA.master));
    mvau_wmem_sched #(.SF(1), .NF(1), .WMEM_DEPTH(1))  dutB (.aclk(aclk), .rst(rst), .bus(ifB.master));
    mvau_wmem_sched #(.SF(4), .NF(3), .WMEM_DEPTH(12)) dutC (.aclk(aclk), .rst(rst), .bus(ifC.master));

    logic [7:0] memA [8];
    logic [7:0] memB [2];
    logic [7:0] memC [16];
    logic [7:0] woutA;
    logic [7:0] woutB;
    logic [7:0] woutC;

    initial begin
        for (int i = 0; i < 8; i++)  memA[i] = 8'(8'h3C + 8'(i * 17));
        for (int i = 0; i < 2; i++)  memB[i] = 8'(8'h5B + 8'(i));
        for (int i = 0; i < 16; i++) memC[i] = 8'(8'hC1 ^ 8'(i * 29));
    end

    always @(posedge aclk) begin
        woutA <= memA[ifA.wmem_addr];
        woutB <= memB[ifB.wmem_addr];
        woutC <= memC[ifC.wmem_addr];
    end

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge aclk);
    endtask

    task automatic chk_beat_a(input string tag, input int k);
        chk({tag, " w_valid"}, 32'(ifA.w_valid), 1);
        chk({tag, " data"},    32'(woutA), 32'(memA[k]));
        chk({tag, " ibuf"},    32'(ifA.ibuf_addr), 32'(k % 3));
        chk({tag, " nf"},      32'(ifA.w_nf), 32'(k / 3));
        chk({tag, " first"},   32'(ifA.w_first), 32'((k % 3) == 0));
        chk({tag, " last"},    32'(ifA.w_last), 32'((k % 3) == 2));
    endtask

    initial begin
        int acc;
        int dn;
        int nb;
        int viol;
        int cdone;
        logic prev_stall;
        logic [7:0] prev_data;
        logic [1:0] prev_ibuf;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        ifA.vec_valid = 1'b0; ifA.w_ready = 1'b1;
        ifB.vec_valid = 1'b0; ifB.w_ready = 1'b1;
        ifC.vec_valid = 1'b0; ifC.w_ready = 1'b1;

        // Reset state
        go(); go(); smp();
        chk("rst w_valid",   32'(ifA.w_valid), 0);
        chk("rst busy",      32'(ifA.busy), 0);
        chk("rst vec_ready", 32'(ifA.vec_ready), 1);
        chk("rst done",      32'(ifA.done), 0);
        chk("rst wmem_addr", 32'(ifA.wmem_addr), 0);
        chk("rst ibuf",      32'(ifA.ibuf_addr), 0);
        chk("rst nf",        32'(ifA.w_nf), 0);
        chk("rst first",     32'(ifA.w_first), 0);
        chk("rst last",      32'(ifA.w_last), 0);
        go(); rst = 1'b0; smp();

        // SF=3 NF=2, full-rate pass
        go(); ifA.vec_valid = 1'b1; smp();
        chk("A1 vec_ready", 32'(ifA.vec_ready), 1);
        go(); ifA.vec_valid = 1'b0; smp();
        chk("A1 busy", 32'(ifA.busy), 1);
        chk("A1 vec_ready busy", 32'(ifA.vec_ready), 0);
        chk("A1 pre w_valid", 32'(ifA.w_valid), 0);
        chk("A1 addr0", 32'(ifA.wmem_addr), 0);
        for (int k = 0; k < 6; k++) begin
            go(); smp();
            chk_beat_a($sformatf("A1 b%0d", k), k);
            chk($sformatf("A1 addr b%0d", k), 32'(ifA.wmem_addr), 32'((k < 5) ? k + 1 : 5));
        end
        go(); smp();
        chk("A1 done", 32'(ifA.done), 1);
        chk("A1 end w_valid", 32'(ifA.w_valid), 0);
        chk("A1 end vec_ready", 32'(ifA.vec_ready), 1);
        chk("A1 end busy", 32'(ifA.busy), 0);
        go(); smp();
        chk("A1 done pulse", 32'(ifA.done), 0);

        // SF=3 NF=2, consumer stalls on beat addr=2
        go(); ifA.vec_valid = 1'b1; smp();
        go(); ifA.vec_valid = 1'b0; smp();
        go(); smp();
        chk_beat_a("A2 b0", 0);
        go(); smp();
        chk_beat_a("A2 b1", 1);
        for (int s = 0; s < 3; s++) begin
            go(); ifA.w_ready = 1'b0; smp();
            chk_beat_a($sformatf("A2 stall%0d", s), 2);
            chk($sformatf("A2 stall%0d addr", s), 32'(ifA.wmem_addr), 2);
            chk($sformatf("A2 stall%0d done", s), 32'(ifA.done), 0);
        end
        go(); ifA.w_ready = 1'b1; smp();
        chk_beat_a("A2 resume", 2);
        chk("A2 resume addr", 32'(ifA.wmem_addr), 3);
        go(); smp();
        chk_beat_a("A2 b3", 3);
        chk("A2 b3 addr", 32'(ifA.wmem_addr), 4);
        go(); smp();
        chk_beat_a("A2 b4", 4);
        go(); smp();
        chk_beat_a("A2 b5", 5);
        go(); smp();
        chk("A2 done", 32'(ifA.done), 1);

        // Reset in the middle of a pass, then restart
        go(); ifA.vec_valid = 1'b1; smp();
        go(); ifA.vec_valid = 1'b0; smp();
        go(); smp(); go(); smp(); go(); smp();
        go(); smp();
        chk_beat_a("A3 b3", 3);
        rst = 1'b1;
        go(); rst = 1'b0; smp();
        chk("A3 rst w_valid", 32'(ifA.w_valid), 0);
        chk("A3 rst busy", 32'(ifA.busy), 0);
        chk("A3 rst vec_ready", 32'(ifA.vec_ready), 1);
        chk("A3 rst addr", 32'(ifA.wmem_addr), 0);
        go(); smp();
        chk("A3 idle w_valid", 32'(ifA.w_valid), 0);
        chk("A3 idle done", 32'(ifA.done), 0);
        go(); ifA.vec_valid = 1'b1; smp();
        chk("A3 re vec_ready", 32'(ifA.vec_ready), 1);
        go(); ifA.vec_valid = 1'b0; smp();
        chk("A3 re addr0", 32'(ifA.wmem_addr), 0);
        chk("A3 re pre w_valid", 32'(ifA.w_valid), 0);
        go(); smp();
        chk_beat_a("A3 re b0", 0);
        for (int k = 1; k < 6; k++) begin
            go(); smp();
            chk_beat_a($sformatf("A3 re b%0d", k), k);
        end
        go(); smp();
        chk("A3 re done", 32'(ifA.done), 1);

        // vec_valid held high across three passes
        acc = 0; dn = 0; nb = 0; viol = 0;
        for (int i = 0; i < 40; i++) begin
            go(); ifA.vec_valid = (acc < 3); smp();
            if (ifA.vec_ready && ifA.vec_valid) acc++;
            if (ifA.busy && ifA.vec_ready) viol++;
            if (ifA.w_valid && ifA.w_ready) begin
                chk($sformatf("A4 data b%0d", nb), 32'(woutA), 32'(memA[nb % 6]));
                chk($sformatf("A4 ibuf b%0d", nb), 32'(ifA.ibuf_addr), 32'(nb % 3));
                nb++;
            end
            if (ifA.done) dn++;
        end
        chk("A4 done pulses", 32'(dn), 3);
        chk("A4 beats", 32'(nb), 18);
        chk("A4 accepts", 32'(acc), 3);
        chk("A4 ready while busy", 32'(viol), 0);

        // SF=1 NF=1, single beat
        go(); ifB.vec_valid = 1'b1; smp();
        chk("B vec_ready", 32'(ifB.vec_ready), 1);
        go(); ifB.vec_valid = 1'b0; smp();
        chk("B pre w_valid", 32'(ifB.w_valid), 0);
        chk("B addr", 32'(ifB.wmem_addr), 0);
        chk("B busy", 32'(ifB.busy), 1);
        go(); smp();
        chk("B w_valid", 32'(ifB.w_valid), 1);
        chk("B first", 32'(ifB.w_first), 1);
        chk("B last", 32'(ifB.w_last), 1);
        chk("B data", 32'(woutB), 32'(memB[0]));
        chk("B ibuf", 32'(ifB.ibuf_addr), 0);
        chk("B nf", 32'(ifB.w_nf), 0);
        go(); smp();
        chk("B done", 32'(ifB.done), 1);
        chk("B end w_valid", 32'(ifB.w_valid), 0);
        chk("B end vec_ready", 32'(ifB.vec_ready), 1);

        // SF=4 NF=3 with random back-pressure
        nb = 0; cdone = 0; prev_stall = 1'b0; prev_data = '0; prev_ibuf = '0;
        go(); ifC.vec_valid = 1'b1; ifC.w_ready = 1'($urandom_range(0, 1)); smp();
        chk("C vec_ready", 32'(ifC.vec_ready), 1);
        for (int i = 0; i < 300 && cdone == 0; i++) begin
            go(); ifC.vec_valid = 1'b0; ifC.w_ready = 1'($urandom_range(0, 1)); smp();
            if (prev_stall) begin
                chk($sformatf("C stall data c%0d", i), 32'(woutC), 32'(prev_data));
                chk($sformatf("C stall ibuf c%0d", i), 32'(ifC.ibuf_addr), 32'(prev_ibuf));
                chk($sformatf("C stall valid c%0d", i), 32'(ifC.w_valid), 1);
            end
            if (ifC.w_valid && ifC.w_ready) begin
                chk($sformatf("C data b%0d", nb), 32'(woutC), 32'(memC[(nb / 4) * 4 + (nb % 4)]));
                chk($sformatf("C ibuf b%0d", nb), 32'(ifC.ibuf_addr), 32'(nb % 4));
                chk($sformatf("C nf b%0d", nb), 32'(ifC.w_nf), 32'(nb / 4));
                chk($sformatf("C first b%0d", nb), 32'(ifC.w_first), 32'((nb % 4) == 0));
                chk($sformatf("C last b%0d", nb), 32'(ifC.w_last), 32'((nb % 4) == 3));
                nb++;
            end
            prev_stall = ifC.w_valid && !ifC.w_ready;
            prev_data  = woutC;
            prev_ibuf  = ifC.ibuf_addr;
            if (ifC.done) cdone++;
        end
        chk("C beats", 32'(nb), 12);
        chk("C done seen", 32'(cdone), 1);
        chk("C end vec_ready", 32'(ifC.vec_ready), 1);
        go(); smp();
        chk("C done pulse", 32'(ifC.done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
